// File: rtl/histo_frame_receiver_if.sv
// Histogram frame receiver bus: serial input pair plus the decoded record,
// frame and error outputs. The slave side is the receiver; the master side
// drives the serial stream and observes the results.
interface histo_frame_receiver_if;
    logic        spi_clk_in;
    logic        spi_mosi_in;
    logic        bin_valid;
    logic [9:0]  bin_index;
    logic [23:0] bin_count;
    logic [7:0]  frame_id;
    logic        frame_done;
    logic [33:0] frame_total;
    logic        err_spacer;
    logic        err_abort;
    logic        err_drop;

    modport master (
        output spi_clk_in, spi_mosi_in,
        input  bin_valid, bin_index, bin_count, frame_id, frame_done,
        input  frame_total, err_spacer, err_abort, err_drop
    );

    modport slave (
        input  spi_clk_in, spi_mosi_in,
        output bin_valid, bin_index, bin_count, frame_id, frame_done,
        output frame_total, err_spacer, err_abort, err_drop
    );
endinterface

// File: rtl/histo_frame_receiver.sv
// Oversampling receiver for the histogram serial stream. Rebuilds 32-bit
// words (8-bit spacer + 24-bit bin count), emits per-bin records, frame id,
// frame total, and flags spacer, abort and dropped-frame faults.
module histo_frame_receiver #(
    parameter int unsigned WORDS_PER_FRAME = 1024,
    parameter int unsigned IDLE_GAP        = 64,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    histo_frame_receiver_if.slave bus
);

    localparam int unsigned     GAP_W    = $clog2(IDLE_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(IDLE_GAP);
    localparam logic [9:0]      LAST_IDX = 10'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {WAIT_GAP, IDLE, SHIFT, EMIT, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   spi_edge;
    logic                   spi_bit;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   gap;

    state_t      state;
    logic [31:0] shift_reg;
    logic [5:0]  bit_cnt;
    logic [9:0]  word_idx;
    logic [33:0] sum;
    logic [7:0]  prev_id;
    logic        prev_valid;

    logic        bin_valid_q;
    logic [9:0]  bin_index_q;
    logic [23:0] bin_count_q;
    logic [7:0]  frame_id_q;
    logic        frame_done_q;
    logic [33:0] frame_total_q;
    logic        err_spacer_q;
    logic        err_abort_q;
    logic        err_drop_q;

    assign spi_edge = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
    assign spi_bit  = mosi_sync[SYNC_STAGES-1];
    assign gap      = (gap_cnt == GAP_MAX);

    // Synchronise the serial pair and remember the previous clock level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync[0] <= bus.spi_clk_in;
            mosi_sync[0] <= bus.spi_mosi_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // Idle-gap counter: cleared by every edge, saturates at IDLE_GAP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if (spi_edge) begin
            gap_cnt <= '0;
        end else if (!gap) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Frame state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= WAIT_GAP;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            word_idx      <= '0;
            sum           <= '0;
            prev_id       <= '0;
            prev_valid    <= 1'b0;
            bin_valid_q   <= 1'b0;
            bin_index_q   <= '0;
            bin_count_q   <= '0;
            frame_id_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_total_q <= '0;
            err_spacer_q  <= 1'b0;
            err_abort_q   <= 1'b0;
            err_drop_q    <= 1'b0;
        end else begin
            bin_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_abort_q  <= 1'b0;
            err_drop_q   <= 1'b0;
            case (state)
                WAIT_GAP: begin
                    if (gap) state <= IDLE;
                end
                IDLE: begin
                    if (spi_edge) begin
                        shift_reg <= {31'd0, spi_bit};
                        bit_cnt   <= 6'd1;
                        word_idx  <= '0;
                        sum       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (spi_edge) begin
                        shift_reg <= {shift_reg[30:0], spi_bit};
                        bit_cnt   <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd31) state <= EMIT;
                    end else if (gap) begin
                        // Covers both a partial word and a pause between words.
                        err_abort_q <= 1'b1;
                        sum         <= '0;
                        state       <= IDLE;
                    end
                end
                EMIT: begin
                    bin_valid_q <= 1'b1;
                    bin_count_q <= shift_reg[23:0];
                    bin_index_q <= (word_idx == '0) ? LAST_IDX : word_idx - 10'd1;
                    if (word_idx == '0) begin
                        frame_id_q <= shift_reg[31:24];
                    end else if (shift_reg[31:24] != 8'd0) begin
                        err_spacer_q <= 1'b1;
                    end
                    sum <= sum + 34'(shift_reg[23:0]);
                    if (word_idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        word_idx <= word_idx + 10'd1;
                        state    <= SHIFT;
                        // An edge landing here is bit 1 of the next word.
                        if (spi_edge) begin
                            shift_reg <= {shift_reg[30:0], spi_bit};
                            bit_cnt   <= 6'd1;
                        end else begin
                            bit_cnt <= 6'd0;
                        end
                    end
                end
                DONE: begin
                    frame_done_q  <= 1'b1;
                    frame_total_q <= sum;
                    err_drop_q    <= prev_valid && (frame_id_q != prev_id + 8'd1);
                    prev_id       <= frame_id_q;
                    prev_valid    <= 1'b1;
                    sum           <= '0;
                    state         <= WAIT_GAP;
                end
                default: state <= WAIT_GAP;
            endcase
        end
    end

    assign bus.bin_valid   = bin_valid_q;
    assign bus.bin_index   = bin_index_q;
    assign bus.bin_count   = bin_count_q;
    assign bus.frame_id    = frame_id_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_total = frame_total_q;
    assign bus.err_spacer  = err_spacer_q;
    assign bus.err_abort   = err_abort_q;
    assign bus.err_drop    = err_drop_q;

endmodule

// File: tb/tb_histo_frame_receiver.sv
// Bench for histo_frame_receiver: directed frame scenarios with random bin
// counts, compared against a word-level reference model of the frame rules.
module tb_histo_frame_receiver;

    localparam int unsigned WPF  = 16;
    localparam int unsigned GAP  = 64;
    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    histo_frame_receiver_if bus();

    histo_frame_receiver #(
        .WORDS_PER_FRAME(WPF),
        .IDLE_GAP(GAP),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    longint unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity
    int unsigned     bin_idx_q[$];
    int unsigned     bin_cnt_q[$];
    longint unsigned bin_cyc_q[$];
    longint unsigned edge32_q[$];
    int done_cnt, abort_cnt, drop_cnt;
    int bits_sent;

    // Reference model state
    logic [31:0] words [WPF];
    logic        model_prev_valid;
    logic [7:0]  model_prev_id;
    logic        model_spacer;
    logic [33:0] model_total;

    always @(negedge clk) begin
        if (bus.bin_valid === 1'b1) begin
            bin_idx_q.push_back(int'(bus.bin_index));
            bin_cnt_q.push_back(int'(bus.bin_count));
            bin_cyc_q.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.err_abort === 1'b1)  abort_cnt++;
        if (bus.err_drop === 1'b1)   drop_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        bin_idx_q.delete();
        bin_cnt_q.delete();
        bin_cyc_q.delete();
        edge32_q.delete();
        done_cnt  = 0;
        abort_cnt = 0;
        drop_cnt  = 0;
    endtask

    task automatic send_bit(input logic b, input int h, input bit last);
        bus.spi_clk_in  = 1'b0;
        bus.spi_mosi_in = b;
        repeat (h) @(negedge clk);
        bus.spi_clk_in = 1'b1;
        bits_sent++;
        if (last) edge32_q.push_back(cyc);
        repeat (h) @(negedge clk);
    endtask

    task automatic send_words(input int n_full, input int tail_bits, input int h);
        for (int w = 0; w < n_full; w++)
            for (int b = 31; b >= 0; b--)
                send_bit(words[w][b], h, b == 0);
        if (tail_bits > 0)
            for (int b = 0; b < tail_bits; b++)
                send_bit(words[n_full][31-b], h, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_random(input logic [7:0] id);
        words[0] = {id, 24'($urandom)};
        for (int k = 1; k < WPF; k++) words[k] = {8'h00, 24'($urandom)};
    endtask

    task automatic model_reset();
        model_prev_valid = 1'b0;
        model_prev_id    = 8'd0;
        model_spacer     = 1'b0;
        model_total      = 34'd0;
    endtask

    task automatic check_frame(input string tag);
        logic [33:0] total;
        logic [7:0]  id;
        logic        drop;
        int          n;
        total = 34'd0;
        for (int k = 0; k < WPF; k++) begin
            total = total + 34'(words[k][23:0]);
            if (k > 0 && words[k][31:24] != 8'd0) model_spacer = 1'b1;
        end
        id   = words[0][31:24];
        drop = model_prev_valid && (id != 8'(model_prev_id + 8'd1));
        check({tag, " bins"}, 64'(bin_idx_q.size()), 64'(WPF));
        n = (bin_idx_q.size() < WPF) ? bin_idx_q.size() : WPF;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s idx%0d", tag, k), 64'(bin_idx_q[k]), 64'((k == 0) ? WPF - 1 : k - 1));
            check($sformatf("%s cnt%0d", tag, k), 64'(bin_cnt_q[k]), 64'(words[k][23:0]));
            if (k < edge32_q.size())
                check($sformatf("%s lat%0d", tag, k), 64'(bin_cyc_q[k] - edge32_q[k]), 64'(SYNC + 2));
        end
        check({tag, " done"}, 64'(done_cnt), 64'd1);
        check({tag, " total"}, 64'(bus.frame_total), 64'(total));
        check({tag, " id"}, 64'(bus.frame_id), 64'(id));
        check({tag, " drop"}, 64'(drop_cnt), 64'(drop));
        check({tag, " abort"}, 64'(abort_cnt), 64'd0);
        check({tag, " spacer"}, 64'(bus.err_spacer), 64'(model_spacer));
        model_prev_valid = 1'b1;
        model_prev_id    = id;
        model_total      = total;
    endtask

    task automatic run_frame(input string tag, input int h);
        clear_mon();
        send_words(WPF, 0, h);
        idle(100);
        check_frame(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        bus.spi_clk_in  = 1'b0;
        bus.spi_mosi_in = 1'b0;
        bits_sent = 0;
        model_reset();
        clear_mon();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst bin_valid", 64'(bus.bin_valid), 64'd0);
        check("rst bin_index", 64'(bus.bin_index), 64'd0);
        check("rst bin_count", 64'(bus.bin_count), 64'd0);
        check("rst frame_id", 64'(bus.frame_id), 64'd0);
        check("rst frame_done", 64'(bus.frame_done), 64'd0);
        check("rst frame_total", 64'(bus.frame_total), 64'd0);
        check("rst err_spacer", 64'(bus.err_spacer), 64'd0);
        check("rst err_abort", 64'(bus.err_abort), 64'd0);
        check("rst err_drop", 64'(bus.err_drop), 64'd0);
        reset = 1'b1;
        idle(100);

        // Good frame with fixed contents, slower SPI
        words[0] = {8'h05, 24'd7};
        for (int k = 1; k < WPF; k++) words[k] = {8'h00, 24'(k)};
        run_frame("good", 3);
        check("good total const", 64'(bus.frame_total), 64'd127);

        // Consecutive ids at clk/4, then a skipped id
        fill_random(8'd6);
        run_frame("id6", 2);
        fill_random(8'd8);
        run_frame("id8", 2);
        check("id8 drop seen", 64'(drop_cnt), 64'd1);

        // Truncated word mid-frame
        fill_random(8'd9);
        clear_mon();
        send_words(5, 20, 2);
        idle(100);
        check("trunc abort", 64'(abort_cnt), 64'd1);
        check("trunc done", 64'(done_cnt), 64'd0);
        check("trunc total", 64'(bus.frame_total), 64'(model_total));
        check("trunc drop", 64'(drop_cnt), 64'd0);
        fill_random(8'd9);
        run_frame("recover", 2);

        // Spacer fault, and stickiness across a clean frame
        fill_random(8'd10);
        words[10] = {8'h01, 24'd3};
        run_frame("spacer", 2);
        check("spacer set", 64'(bus.err_spacer), 64'd1);
        fill_random(8'd11);
        run_frame("spacer hold", 2);

        // Reset during word 8 while SPI keeps toggling
        fill_random(8'd12);
        clear_mon();
        bits_sent = 0;
        fork
            send_words(WPF, 0, 2);
            begin
                budget = 20000;
                while (bits_sent < 8 * 32 + 10 && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                check("midrst reached", 64'(budget > 0), 64'd1);
                reset = 1'b0;
                repeat (2) @(negedge clk);
                check("midrst bin_valid", 64'(bus.bin_valid), 64'd0);
                check("midrst frame_id", 64'(bus.frame_id), 64'd0);
                check("midrst frame_total", 64'(bus.frame_total), 64'd0);
                check("midrst err_spacer", 64'(bus.err_spacer), 64'd0);
                check("midrst err_abort", 64'(bus.err_abort), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                clear_mon();
            end
        join
        model_reset();
        idle(100);
        check("midrst no bins", 64'(bin_idx_q.size()), 64'd0);
        check("midrst no done", 64'(done_cnt), 64'd0);
        check("midrst no abort", 64'(abort_cnt), 64'd0);

        // First frame after reset with id 0xFF, then wrap to 0x00
        fill_random(8'hFF);
        run_frame("ff first", 2);
        fill_random(8'h00);
        run_frame("wrap", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
